data_mem_responder: RTL and testbench

Data-memory responder for the core's memory-stage bus. It accepts one load or store per cycle from the pipeline's MEM stage, performs RISC-V byte, halfword and word stores with lane masking, and returns aligned, sign- or zero-extended load data one cycle later so the WB stage can consume it directly. After reset it optionally zero-fills the array with an internal sequencer and reports readiness to the SoC.

---
 rtl/riscv_types_pkg.sv | 35 +++
 rtl/load_data_align.sv | 28 ++
 rtl/data_mem_responder.sv | 99 +++++++++
 tb/tb_data_mem_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_types_pkg.sv
// riscv_types: shared memory-op and init-state types plus request decode helpers for the data-memory path.
package riscv_types;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_op_t;

    typedef enum logic {
        INIT_CLEAR_S,
        INIT_READY_S
    } init_state_t;

    // Illegal op (unknown funct3, or BU/HU used for a store) or a misaligned H/HU/W access.
    function automatic logic req_bad(input logic [2:0] op, input logic wr, input logic [1:0] off);
        logic legal;
        legal = op == MEM_B || op == MEM_H || op == MEM_W || (!wr && (op == MEM_BU || op == MEM_HU));
        return !legal || (op[1:0] == 2'b01 && off[0]) || (op == MEM_W && off != 2'b00);
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] op, input logic [1:0] off);
        return op[1:0] == 2'b00 ? 4'b0001 << off :
               op[1:0] == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

    // Replicate the right-justified store data onto every lane it could land in.
    function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] wd);
        return op[1:0] == 2'b00 ? {4{wd[7:0]}} :
               op[1:0] == 2'b01 ? {2{wd[15:0]}} : wd;
    endfunction

endpackage

// File: rtl/load_data_align.sv
// load_data_align: picks the addressed byte/halfword from a word and sign- or zero-extends it.
//   word_i   : full 32-bit memory word
//   offset_i : byte offset addr[1:0]
//   op_i     : funct3 of the load
//   data_o   : extended load result
module load_data_align
    import riscv_types::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  op_i,
    output logic [31:0] data_o
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = word_i[8*offset_i +: 8];
    assign h = offset_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        data_o = op_i == MEM_B  ? {{24{b[7]}}, b} :
                 op_i == MEM_BU ? {24'h0, b} :
                 op_i == MEM_H  ? {{16{h[15]}}, h} :
                 op_i == MEM_HU ? {16'h0, h} : word_i;
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage data memory with byte-lane stores, 1-cycle aligned loads and a post-reset zero fill.
//   clk, reset            : clock, asynchronous active-high reset
//   mem_addr/wdata/op     : byte address, right-justified store data, funct3
//   mem_write/mem_read    : store / load request (store wins when both set)
//   hold                  : pipeline freeze, request ignored and outputs held
//   mem_rdata/misaligned  : registered load result and bad-request flag
//   init_done             : array ready for requests
module data_mem_responder
    import riscv_types::*;
#(
    parameter int DMEM_DEPTH = 1024,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [2:0]  mem_op,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic        hold,
    output logic [31:0] mem_rdata,
    output logic        misaligned,
    output logic        init_done
);

    localparam int AW = $clog2(DMEM_DEPTH);

    logic [31:0]   mem [DMEM_DEPTH];
    init_state_t   state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          mis_q, mis_d;
    logic [AW-1:0] idx, wr_idx;
    logic [1:0]    off;
    logic          bad;
    logic [31:0]   load_data, wr_data;
    logic [3:0]    we;
    logic          unused_addr;

    assign idx         = mem_addr[AW+1:2];
    assign off         = mem_addr[1:0];
    assign unused_addr = ^mem_addr[31:AW+2];
    assign bad         = req_bad(mem_op, mem_write, off);

    load_data_align u_align (
        .word_i   (mem[idx]),
        .offset_i (off),
        .op_i     (mem_op),
        .data_o   (load_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        we      = 4'b0000;
        wr_idx  = idx;
        wr_data = store_data(mem_op, mem_wdata);
        if (state_q == INIT_CLEAR_S) begin
            // The fill owns the write port; requests and hold are ignored.
            we      = 4'b1111;
            wr_idx  = cnt_q;
            wr_data = 32'h0;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == AW'(DMEM_DEPTH - 1)) state_d = INIT_READY_S;
        end else if (!hold) begin
            mis_d = (mem_write | mem_read) & bad;
            if (mem_write) we = bad ? 4'b0000 : store_mask(mem_op, off);
            else if (mem_read) rdata_d = bad ? 32'h0 : load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= INIT_CLEAR ? INIT_CLEAR_S : INIT_READY_S;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    // Per-lane enables so the array maps onto byte-write RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
    end

    assign mem_rdata  = rdata_q;
    assign misaligned = mis_q;
    assign init_done  = state_q == INIT_READY_S;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed and randomized checks against a byte-array reference model.
module tb_data_mem_responder;

    localparam int DEPTH = 16;
    localparam int NB    = DEPTH * 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_addr = 32'h0, mem_wdata = 32'h0;
    logic [2:0]  mem_op = 3'b0;
    logic        mem_write = 1'b0, mem_read = 1'b0, hold = 1'b0;
    logic [31:0] mem_rdata;
    logic        misaligned, init_done;

    int checks = 0;
    int errors = 0;

    logic [7:0]  bytes_m [NB];
    logic [31:0] rdata_m;
    logic        mis_m;

    data_mem_responder #(.DMEM_DEPTH(DEPTH), .INIT_CLEAR(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_op     (mem_op),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .hold       (hold),
        .mem_rdata  (mem_rdata),
        .misaligned (misaligned),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) bytes_m[i] = 8'h0;
        rdata_m = 32'h0;
        mis_m   = 1'b0;
    endtask

    // Byte-addressed model: access size, legality and alignment from the funct3 rules.
    task automatic model(input logic w, input logic r, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] op, input logic h);
        int size, base;
        bit legal, bad;
        logic [31:0] v;
        if (h) return;
        if (!w && !r) begin
            mis_m = 1'b0;
            return;
        end
        size  = (op % 4 == 0) ? 1 : (op % 4 == 1) ? 2 : 4;
        legal = (op <= 2) || ((op == 4 || op == 5) && !w);
        base  = int'(a[5:0]);
        bad   = !legal || (base % size != 0);
        mis_m = bad;
        if (w) begin
            if (!bad) for (int k = 0; k < size; k++) bytes_m[base + k] = 8'(wd >> (8 * k));
        end else if (bad) begin
            rdata_m = 32'h0;
        end else begin
            v = 32'h0;
            for (int k = 0; k < size; k++) v |= 32'(bytes_m[base + k]) << (8 * k);
            if (op < 4 && size < 4 && v[8 * size - 1]) v |= 32'hFFFF_FFFF << (8 * size);
            rdata_m = v;
        end
    endtask

    task automatic req(input string tag, input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] op, input logic h);
        mem_write = w; mem_read = r; mem_addr = a; mem_wdata = wd; mem_op = op; hold = h;
        @(posedge clk);
        model(w, r, a, wd, op, h);
        #1;
        chk({tag, ".rdata"}, mem_rdata, rdata_m);
        chk({tag, ".mis"}, 32'(misaligned), 32'(mis_m));
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (!init_done && n < 100) begin
            @(posedge clk);
            n++;
            #1;
        end
        chk(tag, 32'(n), 32'(DEPTH));
        model_reset();
    endtask

    initial begin
        int n;
        logic w, r, h;
        logic [31:0] a;
        logic [2:0] op;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.rdata", mem_rdata, 32'h0);
        chk("rst.mis", 32'(misaligned), 32'h0);
        chk("rst.init_done", 32'(init_done), 32'h0);
        reset = 1'b0;

        // Fill with a store presented at edge 5 that must be ignored.
        n = 0;
        while (!init_done && n < 100) begin
            if (n == 4) begin
                mem_write = 1'b1; mem_read = 1'b1; mem_addr = 32'h20; mem_wdata = 32'hFFFF_FFFF; mem_op = 3'b010;
            end
            if (n == 5) begin
                mem_write = 1'b0; mem_read = 1'b0;
            end
            @(posedge clk);
            n++;
            #1;
        end
        chk("init.edges", 32'(n), 32'(DEPTH));
        chk("init.rdata_held", mem_rdata, 32'h0);
        model_reset();
        req("init.lw20", 0, 1, 32'h20, 0, 3'b010, 0);
        chk("init.lw20_zero", mem_rdata, 32'h0);

        req("sw100", 1, 0, 32'h100, 32'h1122_3344, 3'b010, 0);
        req("sb101", 1, 0, 32'h101, 32'h0000_00AA, 3'b000, 0);
        req("sh102", 1, 0, 32'h102, 32'h0000_BEEF, 3'b001, 0);
        req("lw100", 0, 1, 32'h100, 0, 3'b010, 0);
        chk("lanes.word", mem_rdata, 32'hBEEF_AA44);

        req("sw40", 1, 0, 32'h40, 32'h80FF_7F01, 3'b010, 0);
        req("lb42", 0, 1, 32'h42, 0, 3'b000, 0);
        chk("ext.lb", mem_rdata, 32'hFFFF_FFFF);
        req("lbu42", 0, 1, 32'h42, 0, 3'b100, 0);
        chk("ext.lbu", mem_rdata, 32'h0000_00FF);
        req("lh42", 0, 1, 32'h42, 0, 3'b001, 0);
        chk("ext.lh", mem_rdata, 32'hFFFF_80FF);
        req("lhu40", 0, 1, 32'h40, 0, 3'b101, 0);
        chk("ext.lhu", mem_rdata, 32'h0000_7F01);

        req("sw41", 1, 0, 32'h41, 32'hDEAD_BEEF, 3'b010, 0);
        chk("mis.sw_flag", 32'(misaligned), 32'h1);
        req("lw40", 0, 1, 32'h40, 0, 3'b010, 0);
        chk("mis.sw_nowrite", mem_rdata, 32'h80FF_7F01);
        req("lh43", 0, 1, 32'h43, 0, 3'b001, 0);
        chk("mis.lh_data", mem_rdata, 32'h0);
        chk("mis.lh_flag", 32'(misaligned), 32'h1);
        req("lw40b", 0, 1, 32'h40, 0, 3'b010, 0);
        req("op011", 0, 1, 32'h40, 0, 3'b011, 0);
        chk("mis.op011_data", mem_rdata, 32'h0);
        chk("mis.op011_flag", 32'(misaligned), 32'h1);
        req("idle", 0, 0, 32'h0, 0, 3'b000, 0);
        chk("mis.idle_clear", 32'(misaligned), 32'h0);

        req("sw_h", 1, 0, 32'h100, 32'h1234_5678, 3'b010, 0);
        req("lw_h", 0, 1, 32'h100, 0, 3'b010, 0);
        for (int i = 0; i < 3; i++) begin
            req("hold", 0, 1, 32'h40, 0, 3'b010, 1);
            chk("hold.frozen", mem_rdata, 32'h1234_5678);
        end
        req("both", 1, 1, 32'h60, 32'hCAFE_F00D, 3'b010, 0);
        chk("prio.rdata_kept", mem_rdata, 32'h1234_5678);
        req("lw60", 0, 1, 32'h60, 0, 3'b010, 0);
        chk("prio.stored", mem_rdata, 32'hCAFE_F00D);

        for (int i = 0; i < 300; i++) begin
            w  = 1'($urandom % 2);
            r  = 1'($urandom % 2);
            h  = ($urandom % 6) == 0;
            op = 3'($urandom % 8);
            a  = $urandom;
            if ($urandom % 2 == 1) a[1:0] = 2'b00;
            req("rand", w, r, a, $urandom, op, h);
        end

        req("sw10", 1, 0, 32'h10, 32'h0000_55AA, 3'b010, 0);
        req("lw10", 0, 1, 32'h10, 0, 3'b010, 0);
        req("sw11", 1, 0, 32'h11, 32'h1, 3'b010, 0);
        reset = 1'b1;
        #1;
        chk("rst2.rdata", mem_rdata, 32'h0);
        chk("rst2.mis", 32'(misaligned), 32'h0);
        chk("rst2.init_done", 32'(init_done), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("mid.init_done", 32'(init_done), 32'h0);
        chk("mid.rdata", mem_rdata, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_init("mid.refill_edges");
        req("lw10z", 0, 1, 32'h10, 0, 3'b010, 0);
        chk("mid.cleared", mem_rdata, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
